mio_bus_ctrl: RTL
=================

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 0, extra RAM wait cycles (legal 0..7).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port MemRead  in  1  CPU read request.
REQ-005 SHALL have port MemWrite  in  1  CPU write request.
REQ-006 SHALL have port CPU_MIO  in  1  qualifies MemRead/MemWrite as a bus request.
REQ-007 SHALL have port addr_bus  in  32  CPU byte address.
REQ-008 SHALL have port Data_in  in  32  CPU write data.
REQ-009 SHALL have port Data_out  out  32  read data to CPU.
REQ-010 SHALL have port MIO_ready  out  1  one-cycle transaction-complete pulse to the controller.
REQ-011 SHALL have ports ram_addr out 10 (word address), ram_we out 1, ram_din out 32, ram_dout in 32 (sync-read block RAM, 1-cycle latency).
REQ-012 SHALL have ports led_out out 16 (LED register), sw_in in 16 (switches), btn_in in 5 (buttons).

Function
REQ-013 SHALL detect a request req = CPU_MIO & (MemRead | MemWrite) only in state IDLE; a request in any other state SHALL be ignored.
REQ-014 SHALL treat MemRead & MemWrite both high as a write.
REQ-015 SHALL latch addr_bus, Data_in and direction at the acceptance edge (end of cycle N).
REQ-016 SHALL decode addr_bus[31:28]: 0x0 RAM (word index addr[11:2]); 0xE LED; 0xF with addr[2]=0 input port, addr[2]=1 cycle counter; all other values unmapped.
REQ-017 SHALL implement FSM IDLE -> RAM_ACC -> RESP -> IDLE for RAM, and IDLE -> RESP -> IDLE for LED, input port, counter and unmapped accesses.
REQ-018 RAM_ACC SHALL last 1+RAM_WAIT cycles, driving ram_addr from the latched address throughout; ram_we SHALL be high only in the first RAM_ACC cycle of a write.
REQ-019 RAM read data SHALL be captured into Data_out at the last RAM_ACC edge.
REQ-020 MIO_ready SHALL be high exactly one cycle, in RESP: cycle N+2+RAM_WAIT for RAM, cycle N+1 for all others.
REQ-021 Data_out SHALL be valid while MIO_ready is high and SHALL hold until the next read completes; writes SHALL not change Data_out.
REQ-022 An input-port read SHALL return {11'b0, btn_in, sw_in} sampled in cycle N.
REQ-023 A counter read SHALL return the counter value of cycle N; the counter SHALL increment every cycle and wrap 0xFFFFFFFF -> 0.
REQ-024 An LED write SHALL load Data_in[15:0] at the acceptance edge, visible from cycle N+1; LED reads SHALL return {16'b0, led_out}.
REQ-025 Unmapped reads SHALL return 0; unmapped writes SHALL have no effect; both SHALL still complete with MIO_ready.
REQ-026 A request held high through RESP SHALL be re-accepted only from IDLE, at cycle RESP+1 at the earliest.

Reset
REQ-027 On reset: state IDLE, MIO_ready 0, ram_we 0, Data_out 0, led_out 0, counter 0, latched address/data 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no MIO_ready pulse; a ram_we already high in the reset cycle SHALL still write (synchronous reset).

Structure
REQ-029 SHALL place the FSM state encoding, region decode constants (0x0/0xE/0xF) and the RAM_WAIT default in shared package mio_pkg.
REQ-030 SHALL instantiate the free-running counter as sub-module mio_counter (clk, reset, 32-bit count out).

Verification
REQ-031 RAM write then read, RAM_WAIT=0: write 0xDEADBEEF to 0x0000_0010 -> ram_we high one cycle, ram_addr 4, ready at N+2; read -> Data_out 0xDEADBEEF with ready.
REQ-032 RAM_WAIT=3 read of 0x0000_0004 -> ready exactly at N+5, single cycle.
REQ-033 sw_in=0x00A5, btn_in=5'h11, read 0xF000_0000 -> Data_out 0x001100A5 at N+1.
REQ-034 Write 0x1234ABCD to 0xE000_0000 -> led_out 0xABCD from N+1; read 0x7000_0000 -> Data_out 0, ready pulses.
REQ-035 Counter read at cycle 100 after reset -> Data_out 100; counter forced near 0xFFFFFFFF -> wraps to 0.
REQ-036 Reset during RAM_ACC with RAM_WAIT=3 -> no MIO_ready, IDLE next cycle, next request serviced normally.

Source files
------------

// File: rtl/mio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mio_pkg
//  Brief    : Shared types and constants for the MIO bus controller:
//             FSM state encoding, address-region decode constants and the
//             default RAM wait-state count.
//  Revision : 1.0  initial release
// ============================================================================
package mio_pkg;

  // Default number of extra RAM wait cycles.
  localparam int unsigned c_RAM_WAIT_DEFAULT = 0;

  // Values of addr_bus[31:28] selecting each region.
  localparam logic [3:0] c_REGION_RAM = 4'h0;
  localparam logic [3:0] c_REGION_LED = 4'hE;
  localparam logic [3:0] c_REGION_IO  = 4'hF;

  // Bus FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Decoded target of an access.
  typedef enum logic [2:0] {
    RGN_RAM     = 3'd0,
    RGN_LED     = 3'd1,
    RGN_INPORT  = 3'd2,
    RGN_COUNTER = 3'd3,
    RGN_NONE    = 3'd4
  } region_t;

  // Map the top address nibble (and addr[2] inside the IO page) to a region.
  function automatic region_t mio_decode(input logic [3:0] top, input logic io_sel);
    region_t r;
    r = RGN_NONE;
    case (top)
      c_REGION_RAM: r = RGN_RAM;
      c_REGION_LED: r = RGN_LED;
      c_REGION_IO:  r = io_sel ? RGN_COUNTER : RGN_INPORT;
      default:      r = RGN_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mio_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mio_counter
//  Brief    : Free-running 32-bit cycle counter, wraps 0xFFFFFFFF -> 0.
//  Revision : 1.0  initial release
// ============================================================================
module mio_counter (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Increment every cycle; natural 32-bit overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mio_bus_ctrl
//  Brief    : CPU memory/IO bus controller. Routes single CPU accesses to a
//             sync-read block RAM, an LED register, a switch/button input
//             port or a free-running cycle counter, and returns a one-cycle
//             MIO_ready pulse on completion.
//  Revision : 1.0  initial release
// ============================================================================
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = c_RAM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        CPU_MIO,
  input  logic [31:0] addr_bus,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [15:0] led_out,
  input  logic [15:0] sw_in,
  input  logic [4:0]  btn_in
);

  localparam logic [2:0] c_WAIT_LAST = 3'(RAM_WAIT);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        we_q;
  logic [31:0] data_out_q;
  logic [15:0] led_q;

  logic        w_req;
  logic        w_accept;
  logic        w_last;
  region_t     w_region;
  logic [31:0] w_count;
  logic [31:0] w_rd_data;
  logic        w_unused;

  mio_counter u_counter (
    .clk     (clk),
    .reset   (reset),
    .count_o (w_count)
  );

  assign w_req    = CPU_MIO & (MemRead | MemWrite);
  assign w_accept = (state_q == ST_IDLE) && w_req;
  assign w_last   = (wait_q == c_WAIT_LAST);
  assign w_region = mio_decode(addr_bus[31:28], addr_bus[2]);

  // Address bits that never influence decode or RAM word index.
  assign w_unused = ^{addr_bus[27:12], addr_bus[1:0], addr_q[31:12], addr_q[1:0]};

  // Non-RAM read data, sampled in the request cycle.
  always_comb begin
    w_rd_data = '0;
    case (w_region)
      RGN_LED:     w_rd_data = {16'b0, led_q};
      RGN_INPORT:  w_rd_data = {11'b0, btn_in, sw_in};
      RGN_COUNTER: w_rd_data = w_count;
      default:     w_rd_data = '0;
    endcase
  end

  // FSM state and wait-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: RAM accesses pass through RAM_ACC, all others go
  // straight to RESP; requests are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (w_accept) begin
          state_d = (w_region == RGN_RAM) ? ST_RAM_ACC : ST_RESP;
        end
      end
      ST_RAM_ACC: begin
        if (w_last) begin
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latches, LED register and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      data_out_q <= '0;
      led_q      <= '0;
    end else begin
      if (w_accept) begin
        addr_q <= addr_bus;
        data_q <= Data_in;
        we_q   <= MemWrite;
        if (MemWrite) begin
          if (w_region == RGN_LED) begin
            led_q <= Data_in[15:0];
          end
        end else if (w_region != RGN_RAM) begin
          data_out_q <= w_rd_data;
        end
      end
      if ((state_q == ST_RAM_ACC) && w_last && !we_q) begin
        data_out_q <= ram_dout;
      end
    end
  end

  // In IDLE the RAM address follows the live bus so the sync-read RAM has
  // the word ready during the first RAM_ACC cycle; afterwards it is held.
  assign ram_addr  = (state_q == ST_IDLE) ? addr_bus[11:2] : addr_q[11:2];
  assign ram_we    = (state_q == ST_RAM_ACC) && we_q && (wait_q == 3'd0);
  assign ram_din   = data_q;
  assign MIO_ready = (state_q == ST_RESP);
  assign Data_out  = data_out_q;
  assign led_out   = led_q;

endmodule
`default_nettype wire
